// File: rtl/i2c_pkg.sv
// Shared I2C definitions: data width, R/W bit values, transaction-sequencer
// state encoding and the command record the sequencer latches on accept.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;
  // Widest supported byte-count field; the sequencer zero-extends into this.
  localparam int I2C_LEN_MAX_W  = 16;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE, ADDR_W, WR_DATA, ADDR_R, RD_DATA, STOP
  } i2c_txn_state_t;

  typedef struct packed {
    logic [6:0]               addr;
    logic [I2C_LEN_MAX_W-1:0] wr_len;
    logic [I2C_LEN_MAX_W-1:0] rd_len;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_txn_ctrl.sv
// I2C master transaction sequencer. Takes one command {addr, wr_len, rd_len},
// drives the byte controller through START+addr(W), write burst, repeated
// START+addr(R), read burst and STOP, streaming TX/RX bytes via FIFOs.
// Ports:
//   clk_i / rstn_i (async low) / clr_i (sync soft reset)
//   cmd_*        : command handshake and fields
//   tx_*         : TX FIFO head (show-ahead), tx_ready_o = pop pulse
//   rx_*         : RX FIFO push, rx_ready_i = FIFO not full
//   bc_*         : byte-controller command bits, ack, read data, arb-lost
//   busy_o, done_o (1-cycle pulse), err_nack_o / err_al_o (sticky)
module i2c_txn_ctrl
  import i2c_pkg::*;
#(
  parameter int LEN_WIDTH  = 8,
  parameter bit NACK_ABORT = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [6:0]                cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]      cmd_wr_len_i,
  input  logic [LEN_WIDTH-1:0]      cmd_rd_len_i,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      bc_start_o,
  output logic                      bc_stop_o,
  output logic                      bc_read_o,
  output logic                      bc_write_o,
  output logic                      bc_ack_o,
  output logic [I2C_DATA_WIDTH-1:0] bc_din_o,
  input  logic                      bc_cmd_ack_i,
  input  logic                      bc_ack_i,
  input  logic                      bc_al_i,
  input  logic [I2C_DATA_WIDTH-1:0] bc_dout_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_nack_o,
  output logic                      err_al_o
);

  i2c_txn_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  i2c_cmd_t                  cmd_q, cmd_d;
  logic                      start_q, start_d, stop_q, stop_d;
  logic                      read_q, read_d, write_q, write_d, ack_q, ack_d;
  logic [I2C_DATA_WIDTH-1:0] din_q, din_d, rx_data_q, rx_data_d;
  logic                      tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic                      done_q, done_d, err_nack_q, err_nack_d;
  logic                      err_al_q, err_al_d;

  logic                 issuing, ack_hit, al_hit, nack_stop, wr_nz, rd_nz;
  logic [LEN_WIDTH-1:0] wr_len, rd_len;

  assign wr_len = cmd_q.wr_len[LEN_WIDTH-1:0];
  assign rd_len = cmd_q.rd_len[LEN_WIDTH-1:0];
  assign wr_nz  = (cmd_q.wr_len != '0);
  assign rd_nz  = (cmd_q.rd_len != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    err_nack_d = err_nack_q;
    err_al_d   = err_al_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    issuing    = start_q | stop_q | read_q | write_q;
    // A cmd_ack only counts while a command is actually outstanding.
    ack_hit    = issuing & bc_cmd_ack_i;
    al_hit     = bc_al_i & (state_q != IDLE);
    nack_stop  = ack_hit & bc_ack_i & NACK_ABORT;

    if (al_hit) begin
      // Bus is lost: no STOP, no pop/push even if cmd_ack coincides.
      state_d  = IDLE;
      cnt_d    = '0;
      err_al_d = 1'b1;
      done_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          cmd_d.addr   = cmd_addr_i;
          cmd_d.wr_len = I2C_LEN_MAX_W'(cmd_wr_len_i);
          cmd_d.rd_len = I2C_LEN_MAX_W'(cmd_rd_len_i);
          err_nack_d   = 1'b0;
          err_al_d     = 1'b0;
          // Both lengths zero is an address probe through the write path.
          if (cmd_wr_len_i != '0 || cmd_rd_len_i == '0) begin
            state_d = ADDR_W;
            cnt_d   = cmd_wr_len_i;
          end else begin
            state_d = ADDR_R;
            cnt_d   = cmd_rd_len_i;
          end
        end
        ADDR_W: if (ack_hit) begin
          if (bc_ack_i) err_nack_d = 1'b1;
          if (nack_stop) state_d = STOP;
          else if (wr_nz) begin
            state_d = WR_DATA;
            cnt_d   = wr_len;
          end else if (rd_nz) state_d = ADDR_R;
          else state_d = STOP;
        end
        WR_DATA: if (ack_hit) begin
          tx_ready_d = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (bc_ack_i) err_nack_d = 1'b1;
          if (nack_stop) state_d = STOP;
          else if (cnt_q <= LEN_WIDTH'(1)) state_d = rd_nz ? ADDR_R : STOP;
        end
        ADDR_R: if (ack_hit) begin
          if (bc_ack_i) err_nack_d = 1'b1;
          if (nack_stop) state_d = STOP;
          else begin
            state_d = RD_DATA;
            cnt_d   = rd_len;
          end
        end
        RD_DATA: if (ack_hit) begin
          rx_valid_d = 1'b1;
          rx_data_d  = bc_dout_i;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_q <= LEN_WIDTH'(1)) state_d = STOP;
        end
        STOP: if (ack_hit) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Command bits are a function of the next state, registered, and frozen
  // while a command is outstanding. A pop/push pulse in flight (this cycle or
  // the next) blocks a new data command: the FIFO head / full flag has not
  // yet caught up with the byte just transferred.
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    read_d  = 1'b0;
    write_d = 1'b0;
    ack_d   = 1'b0;
    din_d   = din_q;
    if (issuing && !bc_cmd_ack_i && !al_hit) begin
      start_d = start_q;
      stop_d  = stop_q;
      read_d  = read_q;
      write_d = write_q;
      ack_d   = ack_q;
    end else if (!al_hit) begin
      case (state_d)
        ADDR_W: begin
          start_d = 1'b1;
          write_d = 1'b1;
          din_d   = {cmd_d.addr, I2C_RW_WRITE};
        end
        WR_DATA: if (tx_valid_i && !tx_ready_d && !tx_ready_q) begin
          write_d = 1'b1;
          din_d   = tx_data_i;
        end
        ADDR_R: begin
          start_d = 1'b1;
          write_d = 1'b1;
          din_d   = {cmd_d.addr, I2C_RW_READ};
        end
        RD_DATA: if (rx_ready_i && !rx_valid_d && !rx_valid_q) begin
          read_d = 1'b1;
          ack_d  = (cnt_d == LEN_WIDTH'(1));  // NACK the final byte
        end
        STOP:    stop_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;      cnt_q <= '0;        cmd_q <= '0;
      start_q <= 1'b0;      stop_q <= 1'b0;     read_q <= 1'b0;
      write_q <= 1'b0;      ack_q <= 1'b0;      din_q <= '0;
      tx_ready_q <= 1'b0;   rx_valid_q <= 1'b0; rx_data_q <= '0;
      done_q <= 1'b0;       err_nack_q <= 1'b0; err_al_q <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;      cnt_q <= '0;        cmd_q <= '0;
      start_q <= 1'b0;      stop_q <= 1'b0;     read_q <= 1'b0;
      write_q <= 1'b0;      ack_q <= 1'b0;      din_q <= '0;
      tx_ready_q <= 1'b0;   rx_valid_q <= 1'b0; rx_data_q <= '0;
      done_q <= 1'b0;       err_nack_q <= 1'b0; err_al_q <= 1'b0;
    end else begin
      state_q <= state_d;       cnt_q <= cnt_d;           cmd_q <= cmd_d;
      start_q <= start_d;       stop_q <= stop_d;         read_q <= read_d;
      write_q <= write_d;       ack_q <= ack_d;           din_q <= din_d;
      tx_ready_q <= tx_ready_d; rx_valid_q <= rx_valid_d; rx_data_q <= rx_data_d;
      done_q <= done_d;         err_nack_q <= err_nack_d; err_al_q <= err_al_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign bc_start_o  = start_q;
  assign bc_stop_o   = stop_q;
  assign bc_read_o   = read_q;
  assign bc_write_o  = write_q;
  assign bc_ack_o    = ack_q;
  assign bc_din_o    = din_q;
  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign done_o      = done_q;
  assign err_nack_o  = err_nack_q;
  assign err_al_o    = err_al_q;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// Self-checking bench for i2c_txn_ctrl: table of whole transactions against a
// behavioural byte-controller / FIFO model, plus hand sequences for
// backpressure, arbitration loss and reset mid-read.
module tb_i2c_txn_ctrl;
  import i2c_pkg::*;

  localparam logic [2:0] K_SW = 3'd1, K_W = 3'd2, K_RD = 3'd3, K_P = 3'd4, K_RDN = 3'd5;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0, clr_i = 1'b0, cmd_valid_i = 1'b0, rx_ready_i = 1'b1, bc_al_i = 1'b0;
  logic [6:0] cmd_addr_i = '0;
  logic [7:0] cmd_wr_len_i = '0, cmd_rd_len_i = '0;
  logic       cmd_ready_o, tx_ready_o, rx_valid_o, busy_o, done_o, err_nack_o, err_al_o;
  logic       bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o;
  logic [7:0] rx_data_o, bc_din_o;
  logic [7:0] tx_data_i = '0, bc_dout_i = '0;
  logic       tx_valid_i = 1'b0, bc_cmd_ack_i = 1'b0, bc_ack_i = 1'b0;

  always #5 clk = ~clk;

  i2c_txn_ctrl #(.LEN_WIDTH(8), .NACK_ABORT(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .clr_i(clr_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_wr_len_i(cmd_wr_len_i), .cmd_rd_len_i(cmd_rd_len_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .bc_start_o(bc_start_o), .bc_stop_o(bc_stop_o), .bc_read_o(bc_read_o),
    .bc_write_o(bc_write_o), .bc_ack_o(bc_ack_o), .bc_din_o(bc_din_o),
    .bc_cmd_ack_i(bc_cmd_ack_i), .bc_ack_i(bc_ack_i), .bc_al_i(bc_al_i),
    .bc_dout_i(bc_dout_i), .busy_o(busy_o), .done_o(done_o),
    .err_nack_o(err_nack_o), .err_al_o(err_al_o)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- byte controller + FIFO model ----------------
  // Written by the stimulus process only:
  logic [7:0] tx_mem[16], rd_mem[16];
  int         tx_wr = 0, rd_wr = 0;
  logic       tx_en = 1'b1, nack_addr = 1'b0;
  // Written by the model process only:
  int         tx_rd = 0, rd_rd = 0, wcnt = 0, pops = 0, dones = 0, nrd;
  logic [2:0] k;
  logic [2:0] log_kind[$];
  logic [7:0] log_din[$], rx_got[$];

  logic cmd_act;
  assign cmd_act = bc_start_o | bc_stop_o | bc_read_o | bc_write_o;

  always @(posedge clk) begin
    nrd = tx_rd + (tx_ready_o ? 1 : 0);
    tx_rd      <= nrd;
    tx_valid_i <= tx_en && (nrd < tx_wr);
    tx_data_i  <= tx_mem[nrd & 15];
    if (tx_ready_o) pops <= pops + 1;
    if (done_o) dones <= dones + 1;
    if (rx_valid_o) rx_got.push_back(rx_data_o);
    // Log each command at the edge where the DUT sees its ack.
    if (bc_cmd_ack_i && cmd_act) begin
      if (bc_start_o && bc_write_o) k = K_SW;
      else if (bc_write_o)          k = K_W;
      else if (bc_read_o)           k = bc_ack_o ? K_RDN : K_RD;
      else                          k = K_P;
      log_kind.push_back(k);
      log_din.push_back(bc_din_o);
    end
    bc_cmd_ack_i <= 1'b0;
    if (!cmd_act || bc_cmd_ack_i) wcnt <= 0;
    else if (wcnt == 2) begin
      bc_cmd_ack_i <= 1'b1;
      bc_ack_i     <= bc_start_o && nack_addr;
      wcnt         <= 0;
      if (bc_read_o) begin
        bc_dout_i <= rd_mem[rd_rd & 15];
        rd_rd     <= rd_rd + 1;
      end
    end else wcnt <= wcnt + 1;
  end

  // ---------------- transaction table ----------------
  typedef struct {
    logic [6:0] addr;
    logic [7:0] wr_len, rd_len;
    logic       nack;
    int         n_tx;
    logic [7:0] tx[3];
    int         n_rd;
    logic [7:0] rd[2];
    int         n_cmd;
    logic [2:0] kind[6];
    logic [7:0] din[6];
    logic       exp_nack;
  } vec_t;
  vec_t vt[5];

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wr & 15] = b; tx_wr++;
  endtask
  task automatic push_rd(input logic [7:0] b);
    rd_mem[rd_wr & 15] = b; rd_wr++;
  endtask

  task automatic issue(input logic [6:0] a, input logic [7:0] wl, input logic [7:0] rl);
    cmd_addr_i = a; cmd_wr_len_i = wl; cmd_rd_len_i = rl; cmd_valid_i = 1'b1;
    chk("cmd_ready_idle", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("start_at_n_plus_1", {bc_start_o, bc_write_o}, 2'b11);
  endtask

  task automatic wait_done(input int d0, input string name);
    int t;
    t = 0;
    while (dones == d0 && t < 500) begin @(negedge clk); t++; end
    chk(name, (t < 500), 1);
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    int l0, p0, r0, d0;
    l0 = log_kind.size(); p0 = pops; r0 = rx_got.size(); d0 = dones;
    for (int i = 0; i < vt[idx].n_tx; i++) push_tx(vt[idx].tx[i]);
    for (int i = 0; i < vt[idx].n_rd; i++) push_rd(vt[idx].rd[i]);
    nack_addr = vt[idx].nack;
    issue(vt[idx].addr, vt[idx].wr_len, vt[idx].rd_len);
    wait_done(d0, "vec_done_timeout");
    chk("vec_ncmd", log_kind.size() - l0, vt[idx].n_cmd);
    for (int i = 0; i < vt[idx].n_cmd && (l0 + i) < log_kind.size(); i++) begin
      chk("vec_kind", log_kind[l0+i], vt[idx].kind[i]);
      if (vt[idx].kind[i] == K_SW || vt[idx].kind[i] == K_W)
        chk("vec_din", log_din[l0+i], vt[idx].din[i]);
    end
    chk("vec_pops", pops - p0, vt[idx].n_tx);
    chk("vec_pushes", rx_got.size() - r0, vt[idx].n_rd);
    for (int i = 0; i < vt[idx].n_rd && (r0 + i) < rx_got.size(); i++)
      chk("vec_rx_data", rx_got[r0+i], vt[idx].rd[i]);
    chk("vec_done_count", dones - d0, 1);
    chk("vec_err_nack", err_nack_o, vt[idx].exp_nack);
    chk("vec_err_al", err_al_o, 0);
    chk("vec_idle", {busy_o, cmd_ready_o}, 2'b01);
    nack_addr = 1'b0;
  endtask

  localparam logic [11:0] RST_FLAGS = 12'h800;  // only cmd_ready_o high

  initial begin
    int l0, p0, r0, d0, t, viol;
    logic [7:0] bp_din[5];
    logic [2:0] bp_kind[9];
    logic [7:0] bp_rx[3];

    vt[0] = '{7'h50, 8'd3, 8'd0, 1'b0, 3, '{8'hA1, 8'hB2, 8'hC3}, 0, '{8'h00, 8'h00},
              5, '{K_SW, K_W, K_W, K_W, K_P, 3'd0}, '{8'hA0, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00}, 1'b0};
    vt[1] = '{7'h68, 8'd1, 8'd2, 1'b0, 1, '{8'h75, 8'h00, 8'h00}, 2, '{8'h12, 8'h34},
              6, '{K_SW, K_W, K_SW, K_RD, K_RDN, K_P}, '{8'hD0, 8'h75, 8'hD1, 8'h00, 8'h00, 8'h00}, 1'b0};
    vt[2] = '{7'h50, 8'd0, 8'd0, 1'b1, 0, '{8'h00, 8'h00, 8'h00}, 0, '{8'h00, 8'h00},
              2, '{K_SW, K_P, 3'd0, 3'd0, 3'd0, 3'd0}, '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
    vt[3] = '{7'h3C, 8'd0, 8'd1, 1'b0, 0, '{8'h00, 8'h00, 8'h00}, 1, '{8'h5A, 8'h00},
              3, '{K_SW, K_RDN, K_P, 3'd0, 3'd0, 3'd0}, '{8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    vt[4] = '{7'h22, 8'd2, 8'd0, 1'b1, 0, '{8'h00, 8'h00, 8'h00}, 0, '{8'h00, 8'h00},
              2, '{K_SW, K_P, 3'd0, 3'd0, 3'd0, 3'd0}, '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
    bp_din  = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'hA1};
    bp_kind = '{K_SW, K_W, K_W, K_W, K_SW, K_RD, K_RD, K_RDN, K_P};
    bp_rx   = '{8'h44, 8'h55, 8'h66};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_flags", {cmd_ready_o, busy_o, bc_start_o, bc_stop_o, bc_read_o, bc_write_o,
                        bc_ack_o, done_o, tx_ready_o, rx_valid_o, err_nack_o, err_al_o}, RST_FLAGS);
    chk("reset_din", bc_din_o, 0);
    chk("reset_rx_data", rx_data_o, 0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Backpressure: TX stall after first data pop, RX stall after first push,
    // plus a command offered while busy that must be ignored.
    l0 = log_kind.size(); p0 = pops; r0 = rx_got.size(); d0 = dones;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    push_rd(8'h44); push_rd(8'h55); push_rd(8'h66);
    issue(7'h50, 8'd3, 8'd3);
    t = 0;
    while (!tx_ready_o && t < 200) begin @(negedge clk); t++; end
    chk("bp_first_pop", (t < 200), 1);
    tx_en = 1'b0; viol = 0;
    repeat (10) begin @(negedge clk); if (cmd_act) viol++; end
    chk("bp_tx_stall_quiet", viol, 0);
    cmd_addr_i = 7'h11; cmd_valid_i = 1'b1;
    chk("bp_busy_not_ready", cmd_ready_o, 0);
    @(negedge clk);
    cmd_valid_i = 1'b0; tx_en = 1'b1;
    t = 0;
    while (!rx_valid_o && t < 300) begin @(negedge clk); t++; end
    chk("bp_first_push", (t < 300), 1);
    rx_ready_i = 1'b0; viol = 0;
    repeat (10) begin @(negedge clk); if (cmd_act) viol++; end
    chk("bp_rx_stall_quiet", viol, 0);
    rx_ready_i = 1'b1;
    wait_done(d0, "bp_done_timeout");
    chk("bp_ncmd", log_kind.size() - l0, 9);
    for (int i = 0; i < 9 && (l0 + i) < log_kind.size(); i++) begin
      chk("bp_kind", log_kind[l0+i], bp_kind[i]);
      if (i < 5) chk("bp_din", log_din[l0+i], bp_din[i]);
    end
    chk("bp_pops", pops - p0, 3);
    chk("bp_pushes", rx_got.size() - r0, 3);
    for (int i = 0; i < 3 && (r0 + i) < rx_got.size(); i++) chk("bp_rx_data", rx_got[r0+i], bp_rx[i]);
    repeat (5) @(negedge clk);
    chk("bp_single_done", dones - d0, 1);
    chk("bp_no_err", {err_nack_o, err_al_o, busy_o}, 3'b000);

    // Arbitration loss while the second write byte is outstanding.
    l0 = log_kind.size(); p0 = pops; d0 = dones;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    issue(7'h50, 8'd3, 8'd0);
    t = 0;
    while (!(log_kind.size() - l0 == 2 && bc_write_o) && t < 200) begin @(negedge clk); t++; end
    chk("al_second_write_seen", (t < 200), 1);
    bc_al_i = 1'b1;
    @(negedge clk);
    bc_al_i = 1'b0;
    chk("al_idle_next", {busy_o, cmd_ready_o}, 2'b01);
    chk("al_flags", {err_al_o, done_o, cmd_act, tx_ready_o}, 4'b1100);
    repeat (10) @(negedge clk);
    chk("al_no_stop", log_kind.size() - l0, 2);
    chk("al_one_pop_only", pops - p0, 1);
    chk("al_err_sticky", err_al_o, 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_clears_err_al", err_al_o, 0);

    // Reset mid-read.
    push_rd(8'h01); push_rd(8'h02); push_rd(8'h03);
    issue(7'h68, 8'd0, 8'd3);
    t = 0;
    while (!bc_read_o && t < 200) begin @(negedge clk); t++; end
    chk("rst_read_seen", (t < 200), 1);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_flags", {cmd_ready_o, busy_o, bc_start_o, bc_stop_o, bc_read_o, bc_write_o,
                          bc_ack_o, done_o, tx_ready_o, rx_valid_o, err_nack_o, err_al_o}, RST_FLAGS);
    chk("rst_mid_din", bc_din_o, 0);
    chk("rst_mid_rx_data", rx_data_o, 0);
    l0 = log_kind.size();
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {cmd_ready_o, busy_o}, 2'b10);
    repeat (5) @(negedge clk);
    chk("rst_no_stop", log_kind.size() - l0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

endmodule
